// File: rtl/vga_frame_reader_pkg.sv
// Shared video definitions.
// The raster timing constants are plain macros so the VGA controller and the
// frame reader agree on one set of numbers; the package re-exports them as
// typed defaults plus the window placement and a small range helper.
`ifndef VGA_TIMING_DEFS
`define VGA_TIMING_DEFS
`define VGA_H_VIS  640
`define VGA_H_FP   16
`define VGA_H_SYNC 96
`define VGA_H_BP   48
`define VGA_V_VIS  480
`define VGA_V_FP   10
`define VGA_V_SYNC 2
`define VGA_V_BP   33
`endif

package vga_frame_reader_pkg;

  localparam int H_VIS_DEF  = `VGA_H_VIS;
  localparam int H_FP_DEF   = `VGA_H_FP;
  localparam int H_SYNC_DEF = `VGA_H_SYNC;
  localparam int H_BP_DEF   = `VGA_H_BP;
  localparam int V_VIS_DEF  = `VGA_V_VIS;
  localparam int V_FP_DEF   = `VGA_V_FP;
  localparam int V_SYNC_DEF = `VGA_V_SYNC;
  localparam int V_BP_DEF   = `VGA_V_BP;

  localparam int WIN_X0_DEF = 192;
  localparam int WIN_Y0_DEF = 112;
  // Window edge is tied to the 8-bit column/row address fields.
  localparam int WIN_SIZE   = 256;

  localparam logic [2:0] RGB_BLACK = 3'b000;

  // Unregistered sync/visibility for the pixel the counters currently hold.
  typedef struct packed {
    logic hs;   // active low
    logic vs;   // active low
    logic vis;  // inside the 640x480 active area
  } raw_sync_t;

  // Inclusive range test on 10-bit raster coordinates.
  function automatic logic inRange(input logic [9:0] val,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Video RAM read port used by the frame reader.
// There is no valid/ready pair on this bus: the reader presents an address
// every pixel and the RAM returns the data one Clock later with a fixed
// latency. The reader never stalls and the RAM can never back-pressure it.
//   oReadAddress : {column[7:0], row[7:0]}, driven by the reader (master)
//   iReadData    : {R,G,B}, driven by the RAM (slave)
interface vga_frame_reader_if;
  logic [15:0] oReadAddress;
  logic [2:0]  iReadData;

  modport master (output oReadAddress, input iReadData);
  modport slave  (input oReadAddress, output iReadData);
endinterface

// File: rtl/vga_frame_reader_timing.sv
// vga_timing_gen: raster timing core.
// A phase flop divides Clock by two; the h/v counters step on every edge where
// phase==1, so each pixel lasts two Clocks.
// Ports:
//   Clock, Reset      : system clock, async active-high reset
//   oPixelEdge        : high when the next Clock edge is a pixel step (phase)
//   oHcounter/oVcounter : current raster position
//   oHnext/oVnext     : position the counters take on the next pixel step
//   oFrameStart       : one-Clock pulse after the counters wrap to (0,0)
//   oRaw              : unregistered hs/vs/vis for the current position
module vga_timing_gen
  import vga_frame_reader_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic       oPixelEdge,
  output logic [9:0] oHcounter,
  output logic [9:0] oVcounter,
  output logic [9:0] oHnext,
  output logic [9:0] oVnext,
  output logic       oFrameStart,
  output raw_sync_t  oRaw
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS_V  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_V  = 10'(V_VIS);

  logic       phase;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic [9:0] hNext;
  logic [9:0] vNext;
  logic       hWrap;
  logic       vWrap;
  logic       frameStart;

  always_comb begin
    hWrap = (hCount == H_LAST);
    vWrap = (vCount == V_LAST);
    hNext = hWrap ? 10'd0 : hCount + 10'd1;
    vNext = vCount;
    if (hWrap) begin
      vNext = vWrap ? 10'd0 : vCount + 10'd1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase      <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      frameStart <= 1'b0;
    end else begin
      phase      <= ~phase;
      // Pulse is only ever set on a pixel step, so it lasts a single Clock.
      frameStart <= 1'b0;
      if (phase) begin
        hCount     <= hNext;
        vCount     <= vNext;
        frameStart <= hWrap && vWrap;
      end
    end
  end

  always_comb begin
    oRaw.hs  = !inRange(hCount, HS_START, HS_END);
    oRaw.vs  = !inRange(vCount, VS_START, VS_END);
    oRaw.vis = (hCount < H_VIS_V) && (vCount < V_VIS_V);
  end

  assign oPixelEdge  = phase;
  assign oHcounter   = hCount;
  assign oVcounter   = vCount;
  assign oHnext      = hNext;
  assign oVnext      = vNext;
  assign oFrameStart = frameStart;

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans the 256x256x3 video RAM out as 640x480@60 VGA.
// A 256x256 window at (WIN_X0, WIN_Y0) shows RAM data; other visible pixels
// show iBorderColor; blanking is always black.
// Ports:
//   Clock, Reset   : system clock, async active-high reset
//   iEnable        : 1 = window shows RAM data, 0 = window shows border colour
//   iBorderColor   : {R,G,B} for visible pixels outside the window
//   ram            : video RAM read port (address out, data in one Clock later)
//   oVGA_RGB       : {R,G,B} to pins
//   oHsync, oVsync : active-low syncs
//   oHcounter/oVcounter : raster position
//   oFrameStart    : one-Clock pulse at each frame start
// Pipeline: the read address for a pixel is registered together with the
// counters (stage 0); on the next pixel step the RAM data, syncs and colour
// are registered (stage 1), so all pin outputs lag the counters by one pixel.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF,
  parameter int WIN_X0 = WIN_X0_DEF,
  parameter int WIN_Y0 = WIN_Y0_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iEnable,
  input  logic [2:0]         iBorderColor,
  vga_frame_reader_if.master ram,
  output logic [2:0]         oVGA_RGB,
  output logic               oHsync,
  output logic               oVsync,
  output logic [9:0]         oHcounter,
  output logic [9:0]         oVcounter,
  output logic               oFrameStart
);

  localparam logic [9:0] WX0 = 10'(WIN_X0);
  localparam logic [9:0] WX1 = 10'(WIN_X0 + WIN_SIZE - 1);
  localparam logic [9:0] WY0 = 10'(WIN_Y0);
  localparam logic [9:0] WY1 = 10'(WIN_Y0 + WIN_SIZE - 1);

  logic       pixelEdge;
  logic [9:0] hNext;
  logic [9:0] vNext;
  raw_sync_t  raw;

  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .Clock       (Clock),
    .Reset       (Reset),
    .oPixelEdge  (pixelEdge),
    .oHcounter   (oHcounter),
    .oVcounter   (oVcounter),
    .oHnext      (hNext),
    .oVnext      (vNext),
    .oFrameStart (oFrameStart),
    .oRaw        (raw)
  );

  // Stage 0 looks at the position the counters are about to take, so the
  // registered address lines up with the registered counters.
  logic       hitNext;
  logic [7:0] colOfs;
  logic [7:0] rowOfs;

  assign hitNext = inRange(hNext, WX0, WX1) && inRange(vNext, WY0, WY1);
  assign colOfs  = 8'(hNext - WX0);
  assign rowOfs  = 8'(vNext - WY0);

  logic [15:0] readAddress;
  logic        inWin;      // window hit for the current counter position
  logic [2:0]  rgb;
  logic        hsync;
  logic        vsync;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      readAddress <= '0;
      inWin       <= 1'b0;
      rgb         <= RGB_BLACK;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
    end else if (pixelEdge) begin
      readAddress <= hitNext ? {colOfs, rowOfs} : 16'h0000;
      inWin       <= hitNext;
      hsync       <= raw.hs;
      vsync       <= raw.vs;
      if (!raw.vis) begin
        rgb <= RGB_BLACK;
      end else if (inWin && iEnable) begin
        rgb <= ram.iReadData;
      end else begin
        rgb <= iBorderColor;
      end
    end
  end

  assign ram.oReadAddress = readAddress;
  assign oVGA_RGB         = rgb;
  assign oHsync           = hsync;
  assign oVsync           = vsync;

endmodule
